tone_player: RTL and testbench

Parametrised note player for the Genius sound path. It accepts one note request (note index, duration in ms, rest flag) through a start/ready handshake. It produces a 50%-duty square wave on the speaker pin for exactly that duration, then inserts a fixed silent gap. It signals completion with a one-cycle done pulse, so the game FSM can sequence melodies and per-colour beeps without its own timers.

---
 rtl/genius_tone_pkg.sv | 22 ++
 rtl/tone_player_tick_gen.sv | 30 +++
 rtl/tone_player.sv | 154 +++++++++++++++
 tb/tb_tone_player.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_tone_pkg.sv
// Shared constants and types for the Genius tone player: note period table and FSM states.
package genius_tone_pkg;

    localparam int DEF_CLK_HZ = 50_000_000;

    // Full-period cycle counts at 50 MHz, A-major scale, index 0..7
    localparam logic [17:0] NOTE_PERIOD [8] = '{
        18'd227272, 18'd202478, 18'd180384, 18'd170262,
        18'd151686, 18'd135136, 18'd120392, 18'd113636
    };

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    function automatic logic [17:0] note_period(input logic [2:0] idx, input int shift);
        return NOTE_PERIOD[idx] >> shift;
    endfunction

endpackage

// File: rtl/tone_player_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and pulses tick for one cycle on the wrap.
module tick_gen
    import genius_tone_pkg::*;
#(
    parameter int TICK_DIV = DEF_CLK_HZ / 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr || count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = (count_reg == LAST);

endmodule

// File: rtl/tone_player.sv
// Note player: one note request per start/ready handshake, square wave for dur_ms, fixed gap, done pulse.
module tone_player
    import genius_tone_pkg::*;
#(
    parameter int CLK_HZ    = DEF_CLK_HZ,
    parameter int NOTE_W    = 3,
    parameter int DUR_W     = 10,
    parameter int GAP_MS    = 20,
    parameter int TICK_DIV  = CLK_HZ / 1000,
    parameter int SIM_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  dur_ms,
    input  logic              rest,
    input  logic              mute,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              spk
);

    localparam int GAP_W = $clog2(GAP_MS + 1);
    localparam int REM_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [REM_W-1:0] GAP_REM = REM_W'(GAP_MS);
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    state_t             state_reg, state_next;
    logic [17:0]        phase_reg, phase_next;
    logic [REM_W-1:0]   rem_reg, rem_next;
    logic [NOTE_W-1:0]  note_reg, note_next;
    logic               rest_reg, rest_next;
    logic               spk_reg, spk_next;
    logic               done_reg, done_next;

    logic [NOTE_W-1:0]  note_sel;
    logic [17:0]        period_sel;
    logic [17:0]        half_sel;
    logic               tick;
    logic               tick_clr;

    // In IDLE the incoming note decides the first spk level; afterwards the latched one
    assign note_sel   = (state_reg == IDLE) ? note : note_reg;
    assign period_sel = note_period(3'(note_sel), SIM_SHIFT);
    assign half_sel   = period_sel >> 1;

    // Prescaler restarts on every state change so each phase measures whole ms from its first cycle
    assign tick_clr = (state_reg == IDLE) || (state_next != state_reg);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            rem_reg   <= '0;
            note_reg  <= '0;
            rest_reg  <= 1'b0;
            spk_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            rem_reg   <= rem_next;
            note_reg  <= note_next;
            rest_reg  <= rest_next;
            spk_reg   <= spk_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        rem_next   = rem_reg;
        note_next  = note_reg;
        rest_next  = rest_reg;
        spk_next   = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    note_next  = note;
                    rest_next  = rest;
                    phase_next = '0;
                    if (dur_ms != '0) begin
                        state_next = PLAY;
                        rem_next   = REM_W'(dur_ms);
                        spk_next   = !rest && !mute && (half_sel != '0);
                    end else if (GAP_MS != 0) begin
                        state_next = GAP;
                        rem_next   = GAP_REM;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (abort) begin
                    state_next = IDLE;
                    phase_next = '0;
                    rem_next   = '0;
                end else if (tick && rem_reg == REM_ONE) begin
                    phase_next = '0;
                    if (GAP_MS != 0) begin
                        state_next = GAP;
                        rem_next   = GAP_REM;
                    end else begin
                        state_next = IDLE;
                        rem_next   = '0;
                        done_next  = 1'b1;
                    end
                end else begin
                    if (tick) begin
                        rem_next = rem_reg - REM_ONE;
                    end
                    phase_next = (phase_reg >= period_sel - 18'd1) ? '0 : phase_reg + 18'd1;
                    spk_next   = !rest_reg && !mute && (phase_next < half_sel);
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = IDLE;
                    rem_next   = '0;
                end else if (tick) begin
                    if (rem_reg == REM_ONE) begin
                        state_next = IDLE;
                        rem_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        rem_next = rem_reg - REM_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state_reg == IDLE);
    assign busy  = !ready;
    assign done  = done_reg;
    assign spk   = spk_reg;

endmodule

// File: tb/tb_tone_player.sv
// Randomised bench for tone_player, checked every cycle against a timeline model keyed on acceptance time.
module tb_tone_player;

    localparam int T   = 1000;
    localparam int GAP = 2;
    localparam int SH  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, rest = 1'b0, mute = 1'b0, abort = 1'b0;
    logic [2:0] note = '0;
    logic [9:0] dur_ms = '0;
    logic       ready, busy, done, spk;

    logic       start0 = 1'b0;
    logic [9:0] dur0 = '0;
    logic       ready0, busy0, done0, spk0;

    always #5 clk = ~clk;

    tone_player #(
        .CLK_HZ(50_000_000), .NOTE_W(3), .DUR_W(10), .GAP_MS(GAP),
        .TICK_DIV(T), .SIM_SHIFT(SH)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .note(note), .dur_ms(dur_ms),
        .rest(rest), .mute(mute), .abort(abort),
        .ready(ready), .busy(busy), .done(done), .spk(spk)
    );

    // Second instance with no gap, for the zero-length request corner
    tone_player #(
        .CLK_HZ(50_000_000), .NOTE_W(3), .DUR_W(10), .GAP_MS(0),
        .TICK_DIV(T), .SIM_SHIFT(SH)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .note(3'd2), .dur_ms(dur0),
        .rest(1'b0), .mute(1'b0), .abort(1'b0),
        .ready(ready0), .busy(busy0), .done(done0), .spk(spk0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: expected outputs of each cycle from the acceptance cycle and request fields
    int unsigned base_period [8] = '{227272, 202478, 180384, 170262,
                                     151686, 135136, 120392, 113636};
    int cyc = 0;
    bit m_busy = 0;
    bit e_spk = 0, e_done = 0;
    int t_acc = 0, m_end = 0, m_p = 1, m_h = 0, m_dur = 0;
    bit m_rest = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0;
            e_spk  = 0;
            e_done = 0;
        end else begin
            e_done = 0;
            if (m_busy) begin
                if (abort) m_busy = 0;
                else if (cyc == m_end) begin
                    m_busy = 0;
                    e_done = 1;
                end
            end else if (start && !abort) begin
                t_acc  = cyc - 1;
                m_p    = int'(base_period[note] >> SH);
                m_h    = m_p / 2;
                m_dur  = int'(dur_ms);
                m_rest = rest;
                m_end  = t_acc + (m_dur + GAP) * T + 1;
                if (m_end == cyc) e_done = 1;
                else m_busy = 1;
            end
            e_spk = 0;
            if (m_busy && (cyc - t_acc) <= m_dur * T)
                e_spk = !m_rest && !mute && (((cyc - t_acc - 1) % m_p) < m_h);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("spk",   int'(spk),   int'(e_spk));
            check("ready", int'(ready), int'(!m_busy));
            check("busy",  int'(busy),  int'(m_busy));
            check("done",  int'(done),  int'(e_done));
        end
    end

    task automatic issue(input int n, input int d, input bit r, output int t_n);
        note   = 3'(n);
        dur_ms = 10'(d);
        rest   = r;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_n   = cyc - 1;
    endtask

    task automatic wait_done(input int t_n, output int lat);
        lat = cyc - t_n;
        while (!done && busy && lat <= 20000) begin
            @(negedge clk);
            lat = cyc - t_n;
        end
        if (lat > 20000) check("wait_bound", int'(done), 1);
    endtask

    int t_n, lat;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_busy",  int'(busy),  0);
        check("rst_done",  int'(done),  0);
        check("rst_spk",   int'(spk),   0);
        check("rst_ready0", int'(ready0), 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // note 7, 3 ms: done at N+5001, then back-to-back starts in the done cycle
        issue(7, 3, 0, t_n);
        wait_done(t_n, lat);
        check("lat_note7", lat, 5001);
        $display("req note=7 dur=3 rest=0 latency=%0d", lat);
        issue(0, 1, 0, t_n);
        wait_done(t_n, lat);
        check("lat_note0", lat, 3001);
        $display("req note=0 dur=1 rest=0 latency=%0d", lat);
        issue(1, 2, 1, t_n);
        wait_done(t_n, lat);
        check("lat_rest", lat, 4001);
        $display("req note=1 dur=2 rest=1 latency=%0d", lat);

        // mute window mid-note
        issue(3, 3, 0, t_n);
        repeat (499) @(negedge clk);
        mute = 1'b1;
        repeat (1001) @(negedge clk);
        mute = 1'b0;
        wait_done(t_n, lat);
        check("lat_mute", lat, 5001);
        $display("req note=3 dur=3 rest=0 muted-window latency=%0d", lat);

        // abort mid-PLAY with an ignored start while busy
        issue(5, 3, 0, t_n);
        repeat (199) @(negedge clk);
        note = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (799) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", int'(ready), 1);
        check("abort_spk",   int'(spk),   0);
        check("abort_done",  int'(done),  0);
        $display("req note=5 dur=3 rest=0 aborted at cycle %0d", cyc - t_n);
        repeat (10) @(negedge clk);
        note = 3'd4; dur_ms = 10'd1; abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_wins", int'(busy), 0);
        $display("req note=4 dur=1 with abort: not accepted");
        repeat (5) @(negedge clk);

        // asynchronous reset mid-PLAY while spk is high
        issue(6, 2, 0, t_n);
        repeat (702) @(negedge clk);
        check("pre_rst_spk", int'(spk), 1);
        #2 rst = 1'b1;
        #1;
        check("async_spk",   int'(spk),   0);
        check("async_busy",  int'(busy),  0);
        check("async_ready", int'(ready), 1);
        $display("req note=6 dur=2 rest=0 reset mid-play");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // zero-gap instance: dur 0 completes at N+1, dur 1 at N+1001
        dur0 = 10'd0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("d0_done",  int'(done0),  1);
        check("d0_ready", int'(ready0), 1);
        check("d0_busy",  int'(busy0),  0);
        @(negedge clk);
        check("d0_done_once", int'(done0), 0);
        $display("req gap0 dur=0 done at N+1");
        dur0 = 10'd1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t_n = cyc - 1;
        check("d1_busy", int'(busy0), 1);
        check("d1_spk",  int'(spk0),  1);
        lat = cyc - t_n;
        while (!done0 && lat <= 20000) begin
            @(negedge clk);
            lat = cyc - t_n;
        end
        check("d1_lat", lat, 1001);
        $display("req gap0 dur=1 latency=%0d", lat);
        repeat (3) @(negedge clk);

        // random requests with mute toggles, spurious starts and occasional aborts
        for (int i = 0; i < 8; i++) begin
            int n, d, ab_at;
            bit r, do_abort;
            n = $urandom_range(0, 7);
            d = $urandom_range(0, 3);
            r = ($urandom_range(0, 3) == 0);
            do_abort = ($urandom_range(0, 3) == 0);
            ab_at = $urandom_range(1, (d + GAP) * T);
            issue(n, d, r, t_n);
            lat = cyc - t_n;
            while (!done && busy && lat <= 20000) begin
                if ($urandom_range(0, 199) == 0) mute = !mute;
                start = ($urandom_range(0, 299) == 0);
                note  = 3'($urandom_range(0, 7));
                abort = do_abort && (lat == ab_at);
                @(negedge clk);
                lat = cyc - t_n;
            end
            start = 1'b0; abort = 1'b0; mute = 1'b0;
            if (lat > 20000) check("rand_bound", int'(done), 1);
            $display("req note=%0d dur=%0d rest=%0d abort=%0d end=%0d", n, d, r, do_abort, lat);
        end
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
